ram_arbiter: RTL and testbench

Two-requester arbiter and sequencer for the single-port `RAM_32x4096` memory in the MIPS core. It gives the instruction-fetch port and the data (load/store) port shared access to one unified RAM. It serialises their requests through a three-state FSM, drives the RAM command signals from registers, and returns read data with a one-cycle `done` pulse. It sits between the CPU's fetch/memory stages and the RAM instance.

---
 rtl/ram_arbiter_if.sv | 54 +++++
 rtl/ram_arbiter.sv | 171 +++++++++++++++++
 tb/tb_ram_arbiter.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/ram_arbiter_if.sv
// Purpose : bundles the fetch port, data port and RAM command/response signals of ram_arbiter.
// Latency : none (wires only).
// Backpressure: none here; requesters hold req/addr/data until their done pulse.
//
// Signals:
//   i_req/i_addr -> i_done/i_rdata          instruction fetch port (read only)
//   d_req/d_write/d_addr/d_wdata -> d_done/d_rdata   load/store port
//   ram_address/ram_read/ram_write/ram_writedata -> RAM, ram_readdata <- RAM
//   busy                                     arbiter not in IDLE
// Modports: slave = arbiter side, master = CPU + RAM environment side.
interface ram_arbiter_if #(
    parameter int ADDR_W = 12
);
    // instruction port
    logic              i_req;
    logic [31:0]       i_addr;
    logic              i_done;
    logic [31:0]       i_rdata;
    // data port
    logic              d_req;
    logic              d_write;
    logic [31:0]       d_addr;
    logic [31:0]       d_wdata;
    logic              d_done;
    logic [31:0]       d_rdata;
    // RAM side
    logic [ADDR_W-1:0] ram_address;
    logic              ram_read;
    logic              ram_write;
    logic [31:0]       ram_writedata;
    logic [31:0]       ram_readdata;
    // status
    logic              busy;

    modport slave (
        input  i_req, i_addr,
        output i_done, i_rdata,
        input  d_req, d_write, d_addr, d_wdata,
        output d_done, d_rdata,
        output ram_address, ram_read, ram_write, ram_writedata,
        input  ram_readdata,
        output busy
    );

    modport master (
        output i_req, i_addr,
        input  i_done, i_rdata,
        output d_req, d_write, d_addr, d_wdata,
        input  d_done, d_rdata,
        input  ram_address, ram_read, ram_write, ram_writedata,
        output ram_readdata,
        input  busy
    );
endinterface

// File: rtl/ram_arbiter.sv
// Purpose : arbitrates instruction-fetch and load/store requests onto one single-port 32-bit RAM.
// Latency : req sampled in IDLE -> RAM command for one cycle -> done pulse the cycle after; one access per 3 cycles.
// Backpressure: no ready signal; a requester simply holds req until its done, the loser waits in IDLE.
//
// Ports:
//   clk    in  : clock, all state on rising edge
//   rst_n  in  : asynchronous active-low reset
//   bus    slave modport of ram_arbiter_if (request ports, done/rdata, RAM command, busy)
// Build option:
//   RAM_ARB_RR_EN defined   -> round-robin on simultaneous requests (data port wins first tie)
//   RAM_ARB_RR_EN undefined -> fixed priority, data port always wins
module ram_arbiter #(
    parameter int ADDR_W = 12
) (
    input  logic          clk,
    input  logic          rst_n,
    ram_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    logic [ADDR_W-1:0] r_ram_address;
    logic [ADDR_W-1:0] w_ram_address_nxt;
    logic              r_ram_read;
    logic              w_ram_read_nxt;
    logic              r_ram_write;
    logic              w_ram_write_nxt;
    logic [31:0]       r_ram_writedata;
    logic [31:0]       w_ram_writedata_nxt;

    // Owner of the access in flight (1 = data port) and whether it is a store.
    // The store flag is kept separately because ram_write is already cleared
    // by the time RESP decides whether to pass read data through.
    logic              r_win_d;
    logic              w_win_d_nxt;
    logic              r_win_store;
    logic              w_win_store_nxt;

    logic              w_any_req;
    logic              w_grant_d;

    assign w_any_req = bus.i_req | bus.d_req;

    //------------------------------------------------------------------
    // Arbitration
    //------------------------------------------------------------------
`ifdef RAM_ARB_RR_EN
    // Remembers which port was granted last; reset value "instruction"
    // makes the data port win the first tie after reset.
    logic r_last_i;

    always_comb begin
        w_grant_d = bus.d_req & (~bus.i_req | r_last_i);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_i <= 1'b1;
        end else if (r_state == ST_IDLE && w_any_req) begin
            r_last_i <= ~w_grant_d;
        end
    end
`else
    always_comb begin
        w_grant_d = bus.d_req;
    end
`endif

    //------------------------------------------------------------------
    // FSM next state and registered RAM command
    //------------------------------------------------------------------
    always_comb begin
        w_state_nxt         = r_state;
        w_ram_address_nxt   = r_ram_address;
        w_ram_read_nxt      = r_ram_read;
        w_ram_write_nxt     = r_ram_write;
        w_ram_writedata_nxt = r_ram_writedata;
        w_win_d_nxt         = r_win_d;
        w_win_store_nxt     = r_win_store;

        case (r_state)
            ST_IDLE: begin
                if (w_any_req) begin
                    w_state_nxt = ST_ACCESS;
                    w_win_d_nxt = w_grant_d;
                    if (w_grant_d) begin
                        // byte address -> word address; upper bits wrap
                        w_ram_address_nxt   = bus.d_addr[ADDR_W+1:2];
                        w_ram_read_nxt      = ~bus.d_write;
                        w_ram_write_nxt     = bus.d_write;
                        w_ram_writedata_nxt = bus.d_wdata;
                        w_win_store_nxt     = bus.d_write;
                    end else begin
                        // the fetch port can only ever read
                        w_ram_address_nxt   = bus.i_addr[ADDR_W+1:2];
                        w_ram_read_nxt      = 1'b1;
                        w_ram_write_nxt     = 1'b0;
                        w_ram_writedata_nxt = 32'd0;
                        w_win_store_nxt     = 1'b0;
                    end
                end
            end
            ST_ACCESS: begin
                // RAM acts on the edge that closes this cycle; drop the
                // command on that same edge so it is a single-cycle strobe.
                w_state_nxt     = ST_RESP;
                w_ram_read_nxt  = 1'b0;
                w_ram_write_nxt = 1'b0;
            end
            ST_RESP: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt     = ST_IDLE;
                w_ram_read_nxt  = 1'b0;
                w_ram_write_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state         <= ST_IDLE;
            r_ram_address   <= '0;
            r_ram_read      <= 1'b0;
            r_ram_write     <= 1'b0;
            r_ram_writedata <= 32'd0;
            r_win_d         <= 1'b0;
            r_win_store     <= 1'b0;
        end else begin
            r_state         <= w_state_nxt;
            r_ram_address   <= w_ram_address_nxt;
            r_ram_read      <= w_ram_read_nxt;
            r_ram_write     <= w_ram_write_nxt;
            r_ram_writedata <= w_ram_writedata_nxt;
            r_win_d         <= w_win_d_nxt;
            r_win_store     <= w_win_store_nxt;
        end
    end

    //------------------------------------------------------------------
    // Outputs
    //------------------------------------------------------------------
    logic w_resp;
    assign w_resp = (r_state == ST_RESP);

    assign bus.ram_address   = r_ram_address;
    assign bus.ram_read      = r_ram_read;
    assign bus.ram_write     = r_ram_write;
    assign bus.ram_writedata = r_ram_writedata;
    assign bus.busy          = (r_state != ST_IDLE);

    // done decodes straight from state so an async reset in RESP kills it at once
    assign bus.i_done  = w_resp & ~r_win_d;
    assign bus.d_done  = w_resp &  r_win_d;
    assign bus.i_rdata = (w_resp & ~r_win_d)                ? bus.ram_readdata : 32'd0;
    assign bus.d_rdata = (w_resp &  r_win_d & ~r_win_store) ? bus.ram_readdata : 32'd0;

    // address bits outside the word-address window are deliberately ignored
    logic w_unused;
    assign w_unused = ^{bus.i_addr[31:ADDR_W+2], bus.i_addr[1:0],
                        bus.d_addr[31:ADDR_W+2], bus.d_addr[1:0]};

endmodule

// File: tb/tb_ram_arbiter.sv
module tb_ram_arbiter;
    localparam int ADDR_W = 12;

    logic clk = 1'b0;
    logic rst_n;

    ram_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

    ram_arbiter #(.ADDR_W(ADDR_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // behavioural single-port RAM: write at the edge, read data the cycle after
    logic [31:0] mem [0:(1<<ADDR_W)-1];
    always @(posedge clk) begin
        if (bus.ram_write) mem[bus.ram_address] <= bus.ram_writedata;
        if (bus.ram_read)  bus.ram_readdata     <= mem[bus.ram_address];
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    typedef struct {
        string       name;
        logic        ireq;
        logic        dreq;
        logic        dwr;
        logic [31:0] iaddr;
        logic [31:0] daddr;
        logic [31:0] wdata;
        logic        exp_d;      // 1 = data port expected to be served
        logic [11:0] exp_raddr;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs [10];

    task automatic drop_reqs();
        bus.i_req   = 1'b0;
        bus.d_req   = 1'b0;
        bus.d_write = 1'b0;
    endtask

    // one isolated access: drive at a negedge, check ACCESS, RESP and back in IDLE
    task automatic run_vec(input int k);
        vec_t v;
        v = vecs[k];
        @(negedge clk);
        bus.i_req   = v.ireq;
        bus.d_req   = v.dreq;
        bus.d_write = v.dwr;
        bus.i_addr  = v.iaddr;
        bus.d_addr  = v.daddr;
        bus.d_wdata = v.wdata;
        @(posedge clk);
        @(negedge clk);
        check({v.name, ".acc_busy"},  bus.busy, 1);
        check({v.name, ".acc_addr"},  bus.ram_address, v.exp_raddr);
        check({v.name, ".acc_read"},  bus.ram_read,  !(v.exp_d && v.dwr));
        check({v.name, ".acc_write"}, bus.ram_write, v.exp_d && v.dwr);
        check({v.name, ".acc_nodone"}, {bus.i_done, bus.d_done}, 0);
        @(posedge clk);
        @(negedge clk);
        check({v.name, ".i_done"}, bus.i_done, !v.exp_d);
        check({v.name, ".d_done"}, bus.d_done, v.exp_d);
        check({v.name, ".rdata"},  v.exp_d ? bus.d_rdata : bus.i_rdata, v.exp_rdata);
        check({v.name, ".other_rdata"}, v.exp_d ? bus.i_rdata : bus.d_rdata, 0);
        check({v.name, ".resp_cmd"}, {bus.ram_read, bus.ram_write}, 0);
        drop_reqs();
        @(posedge clk);
        @(negedge clk);
        check({v.name, ".idle"}, {bus.busy, bus.i_done, bus.d_done}, 0);
        check({v.name, ".idle_rdata"}, bus.i_rdata | bus.d_rdata, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    logic exp_ord [4];

    initial begin
        vecs[0] = '{"st10",    0, 1, 1, 32'h0, 32'h0000_0010, 32'hDEAD_BEEF, 1, 12'h004, 32'h0};
        vecs[1] = '{"ld10",    0, 1, 0, 32'h0, 32'h0000_0010, 32'h0,         1, 12'h004, 32'hDEAD_BEEF};
        vecs[2] = '{"st0c",    0, 1, 1, 32'h0, 32'h0000_000C, 32'h2408_0005, 1, 12'h003, 32'h0};
        vecs[3] = '{"if0c",    1, 0, 0, 32'h0000_000C, 32'h0, 32'h0,         0, 12'h003, 32'h2408_0005};
        vecs[4] = '{"st08",    0, 1, 1, 32'h0, 32'h0000_0008, 32'hCAFE_F00D, 1, 12'h002, 32'h0};
        vecs[5] = '{"ldwrap",  0, 1, 0, 32'h0, 32'h0000_4008, 32'h0,         1, 12'h002, 32'hCAFE_F00D};
        vecs[6] = '{"ldlow",   0, 1, 0, 32'h0, 32'h0000_800B, 32'h0,         1, 12'h002, 32'hCAFE_F00D};
        vecs[7] = '{"sttop",   0, 1, 1, 32'h0, 32'h0000_3FFC, 32'h1234_5678, 1, 12'hFFF, 32'h0};
        vecs[8] = '{"ldtop",   0, 1, 0, 32'h0, 32'h0000_3FFC, 32'h0,         1, 12'hFFF, 32'h1234_5678};
        vecs[9] = '{"iftop",   1, 0, 0, 32'hFFFF_FFFC, 32'h0, 32'h0,         0, 12'hFFF, 32'h1234_5678};

`ifdef RAM_ARB_RR_EN
        exp_ord = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
        exp_ord = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif

        // ---------------- reset ----------------
        rst_n       = 1'b0;
        bus.i_req   = 1'b0;
        bus.i_addr  = 32'h0;
        bus.d_req   = 1'b0;
        bus.d_write = 1'b0;
        bus.d_addr  = 32'h0;
        bus.d_wdata = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("rst.busy",     bus.busy, 0);
        check("rst.cmd",      {bus.ram_read, bus.ram_write}, 0);
        check("rst.addr",     bus.ram_address, 0);
        check("rst.wdata",    bus.ram_writedata, 0);
        check("rst.done",     {bus.i_done, bus.d_done}, 0);
        check("rst.rdata",    bus.i_rdata | bus.d_rdata, 0);

        // ---------------- single accesses ----------------
        for (int k = 0; k < 10; k++) run_vec(k);

        // ---------------- contention: both held for 4 accesses ----------------
        @(negedge clk);
        bus.i_req   = 1'b1;
        bus.i_addr  = 32'h0000_000C;
        bus.d_req   = 1'b1;
        bus.d_write = 1'b0;
        bus.d_addr  = 32'h0000_0010;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            @(posedge clk);
            @(negedge clk);
            check($sformatf("cont%0d.d_done", k), bus.d_done, exp_ord[k]);
            check($sformatf("cont%0d.i_done", k), bus.i_done, !exp_ord[k]);
            check($sformatf("cont%0d.rdata", k), exp_ord[k] ? bus.d_rdata : bus.i_rdata,
                  exp_ord[k] ? 32'hDEAD_BEEF : 32'h2408_0005);
            if (k == 3) bus.d_req = 1'b0;
            @(posedge clk);
        end
`ifndef RAM_ARB_RR_EN
        // instruction port is served once the data port lets go
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check("cont_tail.i_done", bus.i_done, 1);
        check("cont_tail.d_done", bus.d_done, 0);
        check("cont_tail.rdata",  bus.i_rdata, 32'h2408_0005);
        @(posedge clk);
`endif
        bus.i_req = 1'b0;
        @(negedge clk);
        check("cont_end.idle", {bus.busy, bus.i_done, bus.d_done}, 0);

        // ---------------- reset during ACCESS of a load ----------------
        @(negedge clk);
        bus.d_req   = 1'b1;
        bus.d_write = 1'b0;
        bus.d_addr  = 32'h0000_0010;
        @(posedge clk);
        @(negedge clk);
        check("mid.read_before", bus.ram_read, 1);
        #2 rst_n = 1'b0;
        #1;
        check("mid.read_drop", bus.ram_read, 0);
        check("mid.busy_drop", bus.busy, 0);
        @(negedge clk);
        check("mid.no_done", {bus.i_done, bus.d_done}, 0);
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("mid.reacc_read", bus.ram_read, 1);
        check("mid.reacc_addr", bus.ram_address, 12'h004);
        @(posedge clk);
        @(negedge clk);
        check("mid.d_done",  bus.d_done, 1);
        check("mid.d_rdata", bus.d_rdata, 32'hDEAD_BEEF);
        drop_reqs();
        @(posedge clk);

        // ---------------- reset during RESP of a fetch ----------------
        @(negedge clk);
        bus.i_req  = 1'b1;
        bus.i_addr = 32'h0000_000C;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check("resp.i_done_pre", bus.i_done, 1);
        bus.i_req = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        check("resp.i_done_drop",  bus.i_done, 0);
        check("resp.i_rdata_drop", bus.i_rdata, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("resp.idle", {bus.busy, bus.i_done, bus.d_done}, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
